// File: rtl/slave_bus_pkg.sv
// Shared definitions for the slave side of the serial bus.
// Instruction codes are common with the master event handler.
package slave_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_MEM,
        RD_REQ,
        RD_CAP,
        RD_SEND,
        DONE
    } state_t;

    localparam logic [1:0] INSTR_IDLE  = 2'b00;
    localparam logic [1:0] INSTR_WRITE = 2'b10;
    localparam logic [1:0] INSTR_READ  = 2'b11;

endpackage

// File: rtl/slave_burst_ctr.sv
// Burst address register and beat counter for the slave event handler.
// Address steps wrap modulo 2^ADDR_LEN; a zero burst loads as one beat.
module slave_burst_ctr #(
    parameter int ADDR_LEN  = 12,
    parameter int BURST_LEN = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ADDR_LEN-1:0]  load_addr,
    input  logic [BURST_LEN-1:0] load_burst,
    input  logic                 step_beat,
    input  logic                 step_addr,
    output logic [ADDR_LEN-1:0]  addr,
    output logic                 last
);

    logic [BURST_LEN-1:0] beats;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr  <= '0;
            beats <= '0;
        end else if (load) begin
            addr  <= load_addr;
            beats <= (load_burst == '0) ? BURST_LEN'(1) : load_burst;
        end else begin
            if (step_addr)
                addr <= addr + ADDR_LEN'(1);
            if (step_beat)
                beats <= beats - BURST_LEN'(1);
        end
    end

    assign last = (beats == BURST_LEN'(1));

endmodule

// File: rtl/slave_event_handler.sv
// Slave event handler: runs decoded bus commands against local memory.
// Optional range check enabled by defining SLAVE_ADDR_CHECK_EN.
module slave_event_handler
    import slave_bus_pkg::*;
#(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd_instr,
    input  logic [ADDR_LEN-1:0]  cmd_addr,
    input  logic [BURST_LEN-1:0] cmd_burst,
    input  logic                 wr_valid,
    input  logic [DATA_LEN-1:0]  wr_data,
    input  logic                 tx_done,
    output logic                 rd_valid,
    output logic [DATA_LEN-1:0]  rd_data,
    output logic                 trans_done,
    output logic                 busy,
    output logic                 addr_err,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic [DATA_LEN-1:0]  mem_wdata,
    output logic                 mem_we,
    input  logic [DATA_LEN-1:0]  mem_rdata
);

    localparam logic [ADDR_LEN:0] DEPTH_W = (ADDR_LEN+1)'(MEM_DEPTH);

    state_t state, state_d;

    logic                busy_d, mem_we_d, rd_valid_d, trans_done_d;
    logic [DATA_LEN-1:0] mem_wdata_d, rd_data_d;
    logic                load, step_beat, step_addr, last;
    logic                oob, in_range;

    slave_burst_ctr #(
        .ADDR_LEN  (ADDR_LEN),
        .BURST_LEN (BURST_LEN)
    ) u_ctr (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_addr  (cmd_addr),
        .load_burst (cmd_burst),
        .step_beat  (step_beat),
        .step_addr  (step_addr),
        .addr       (mem_addr),
        .last       (last)
    );

    assign oob = ({1'b0, mem_addr} >= DEPTH_W);

`ifdef SLAVE_ADDR_CHECK_EN
    logic err_q;

    assign in_range = ~oob;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_q <= 1'b0;
        else if (oob && ((state == WR_WAIT && wr_valid) || state == RD_CAP))
            err_q <= 1'b1;
    end

    assign addr_err = err_q;
`else
    logic unused_oob;

    assign unused_oob = oob;
    assign in_range   = 1'b1;
    assign addr_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            trans_done <= 1'b0;
        end else begin
            state      <= state_d;
            busy       <= busy_d;
            mem_we     <= mem_we_d;
            mem_wdata  <= mem_wdata_d;
            rd_valid   <= rd_valid_d;
            rd_data    <= rd_data_d;
            trans_done <= trans_done_d;
        end
    end

    always_comb begin
        state_d      = state;
        busy_d       = busy;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata;
        rd_valid_d   = rd_valid;
        rd_data_d    = rd_data;
        trans_done_d = 1'b0;
        load         = 1'b0;
        step_beat    = 1'b0;
        step_addr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_instr == INSTR_WRITE) begin
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = WR_WAIT;
                end else if (cmd_valid && cmd_instr == INSTR_READ) begin
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = RD_REQ;
                end
            end
            WR_WAIT: begin
                if (wr_valid) begin
                    mem_wdata_d = wr_data;
                    mem_we_d    = in_range;
                    state_d     = WR_MEM;
                end
            end
            WR_MEM: begin
                step_beat = 1'b1;
                step_addr = 1'b1;
                if (last) begin
                    trans_done_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    state_d = WR_WAIT;
                end
            end
            RD_REQ: state_d = RD_CAP;
            RD_CAP: begin
                rd_data_d  = in_range ? mem_rdata : '0;
                rd_valid_d = 1'b1;
                state_d    = RD_SEND;
            end
            RD_SEND: begin
                if (tx_done) begin
                    rd_valid_d = 1'b0;
                    step_beat  = 1'b1;
                    if (last) begin
                        trans_done_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        step_addr = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_slave_event_handler.sv
// Directed bench for slave_event_handler with a registered-read memory model.
// Define SLAVE_ADDR_CHECK_EN to also exercise the range check (MEM_DEPTH=256).
module tb_slave_event_handler;

`ifdef SLAVE_ADDR_CHECK_EN
    localparam int DEPTH = 256;
`else
    localparam int DEPTH = 4096;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_instr = 2'b00;
    logic [11:0] cmd_addr = '0;
    logic [11:0] cmd_burst = '0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        tx_done = 1'b0;
    logic        rd_valid, trans_done, busy, addr_err, mem_we;
    logic [7:0]  rd_data, mem_wdata;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  mem [4096];
    int          vectors = 0;
    int          miscompares = 0;
    int          tdone_cnt = 0;
    int          t0;

    slave_event_handler #(
        .ADDR_LEN  (12),
        .DATA_LEN  (8),
        .BURST_LEN (12),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_instr  (cmd_instr),
        .cmd_addr   (cmd_addr),
        .cmd_burst  (cmd_burst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .tx_done    (tx_done),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .trans_done (trans_done),
        .busy       (busy),
        .addr_err   (addr_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (trans_done)
            tdone_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] i, input logic [11:0] a,
                            input logic [11:0] b);
        cmd_valid = 1'b1;
        cmd_instr = i;
        cmd_addr  = a;
        cmd_burst = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if ({rd_valid, rd_data, trans_done, busy, addr_err,
             mem_addr, mem_wdata, mem_we} !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b rd_valid=%b addr=%h expected all 0",
                     busy, rd_valid, mem_addr);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        t0 = tdone_cnt;
        send_cmd(2'b10, 12'h010, 12'd1);
        vectors++;
        if (busy !== 1'b1 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_accept: busy=%b we=%b expected 1/0", busy, mem_we);
        end
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        tick();
        wr_valid = 1'b0;
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h010, 8'hA5}) begin
            miscompares++;
            $display("FAIL sw_write: we=%b addr=%h data=%h expected 1/010/a5",
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        vectors++;
        if ({mem_we, trans_done, busy} !== 3'b011) begin
            miscompares++;
            $display("FAIL sw_done: we/td/busy=%b%b%b expected 011",
                     mem_we, trans_done, busy);
        end
        tick();
        vectors++;
        if ({trans_done, busy} !== 2'b00 || mem[12'h010] !== 8'hA5
            || tdone_cnt - t0 != 1) begin
            miscompares++;
            $display("FAIL sw_idle: td=%b busy=%b mem=%h pulses=%0d expected 0/0/a5/1",
                     trans_done, busy, mem[12'h010], tdone_cnt - t0);
        end
    endtask

    task automatic test_write_wrap();
        t0 = tdone_cnt;
        send_cmd(2'b10, 12'hFFE, 12'd3);
        cmd_valid = 1'b1;
        cmd_instr = 2'b11;
        cmd_addr  = 12'h200;
        cmd_burst = 12'd5;
        tx_done   = 1'b1;
        wr_valid  = 1'b1;
        wr_data   = 8'h11;
        tick();
        cmd_valid = 1'b0;
        tx_done   = 1'b0;
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'hFFE, 8'h11}) begin
            miscompares++;
            $display("FAIL wrap_b0: we=%b addr=%h data=%h expected 1/ffe/11",
                     mem_we, mem_addr, mem_wdata);
        end
        wr_data = 8'hEE;
        tick();
        wr_valid = 1'b0;
        vectors++;
        if (mem_we !== 1'b0 || mem_addr !== 12'hFFF) begin
            miscompares++;
            $display("FAIL wrap_drop: we=%b addr=%h expected 0/fff", mem_we, mem_addr);
        end
        wr_valid = 1'b1;
        wr_data  = 8'h22;
        tick();
        wr_valid = 1'b0;
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'hFFF, 8'h22}) begin
            miscompares++;
            $display("FAIL wrap_b1: we=%b addr=%h data=%h expected 1/fff/22",
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        wr_valid = 1'b1;
        wr_data  = 8'h33;
        tick();
        wr_valid = 1'b0;
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h000, 8'h33}) begin
            miscompares++;
            $display("FAIL wrap_b2: we=%b addr=%h data=%h expected 1/000/33",
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        vectors++;
        if ({mem_we, trans_done, busy} !== 3'b011) begin
            miscompares++;
            $display("FAIL wrap_done: we/td/busy=%b%b%b expected 011",
                     mem_we, trans_done, busy);
        end
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || tdone_cnt - t0 != 1 || mem[12'hFFE] !== 8'h11
            || mem[12'hFFF] !== 8'h22 || mem[12'h000] !== 8'h33) begin
            miscompares++;
            $display("FAIL wrap_end: busy=%b pulses=%0d mem=%h/%h/%h expected 0/1/11/22/33",
                     busy, tdone_cnt - t0, mem[12'hFFE], mem[12'hFFF], mem[12'h000]);
        end
    endtask

    task automatic test_read_burst();
        t0 = tdone_cnt;
        mem[12'h100] = 8'h5A;
        mem[12'h101] = 8'hC3;
        send_cmd(2'b11, 12'h100, 12'd2);
        tick();
        vectors++;
        if (rd_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_early: rd_valid=%b busy=%b expected 0/1", rd_valid, busy);
        end
        tick();
        vectors++;
        if ({rd_valid, rd_data} !== {1'b1, 8'h5A}) begin
            miscompares++;
            $display("FAIL rd_b0: valid=%b data=%h expected 1/5a", rd_valid, rd_data);
        end
        tick();
        tick();
        vectors++;
        if ({rd_valid, rd_data} !== {1'b1, 8'h5A}) begin
            miscompares++;
            $display("FAIL rd_hold: valid=%b data=%h expected 1/5a", rd_valid, rd_data);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        vectors++;
        if (rd_valid !== 1'b0 || mem_addr !== 12'h101 || trans_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_step: valid=%b addr=%h td=%b expected 0/101/0",
                     rd_valid, mem_addr, trans_done);
        end
        tick();
        tick();
        vectors++;
        if ({rd_valid, rd_data} !== {1'b1, 8'hC3}) begin
            miscompares++;
            $display("FAIL rd_b1: valid=%b data=%h expected 1/c3", rd_valid, rd_data);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        vectors++;
        if ({rd_valid, trans_done, busy} !== 3'b011) begin
            miscompares++;
            $display("FAIL rd_done: valid/td/busy=%b%b%b expected 011",
                     rd_valid, trans_done, busy);
        end
        tick();
        vectors++;
        if ({trans_done, busy} !== 2'b00 || tdone_cnt - t0 != 1) begin
            miscompares++;
            $display("FAIL rd_idle: td=%b busy=%b pulses=%0d expected 0/0/1",
                     trans_done, busy, tdone_cnt - t0);
        end
    endtask

    task automatic test_burst_zero();
        t0 = tdone_cnt;
        send_cmd(2'b10, 12'h020, 12'd0);
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        tick();
        wr_valid = 1'b0;
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h020, 8'h77}) begin
            miscompares++;
            $display("FAIL b0_write: we=%b addr=%h data=%h expected 1/020/77",
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        vectors++;
        if (trans_done !== 1'b1) begin
            miscompares++;
            $display("FAIL b0_done: td=%b expected 1", trans_done);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || tdone_cnt - t0 != 1) begin
            miscompares++;
            $display("FAIL b0_idle: busy=%b pulses=%0d expected 0/1", busy, tdone_cnt - t0);
        end
    endtask

    task automatic test_illegal_instr();
        send_cmd(2'b01, 12'h040, 12'd2);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ill_busy: busy=%b expected 0", busy);
        end
        wr_valid = 1'b1;
        wr_data  = 8'hAB;
        tick();
        wr_valid = 1'b0;
        tick();
        vectors++;
        if ({mem_we, busy, rd_valid, trans_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL ill_quiet: we/busy/rv/td=%b%b%b%b expected 0000",
                     mem_we, busy, rd_valid, trans_done);
        end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1;
        cmd_instr = 2'b10;
        cmd_addr  = 12'h030;
        cmd_burst = 12'd1;
        wr_valid  = 1'b1;
        wr_data   = 8'h99;
        tick();
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        tick();
        vectors++;
        if (mem_we !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_drop: we=%b busy=%b expected 0/1", mem_we, busy);
        end
        wr_valid = 1'b1;
        wr_data  = 8'h44;
        tick();
        wr_valid = 1'b0;
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h030, 8'h44}) begin
            miscompares++;
            $display("FAIL b2b_write: we=%b addr=%h data=%h expected 1/030/44",
                     mem_we, mem_addr, mem_wdata);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_read();
        t0 = tdone_cnt;
        send_cmd(2'b11, 12'h101, 12'd2);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({rd_valid, rd_data, trans_done, busy, addr_err,
             mem_addr, mem_wdata, mem_we} !== 33'd0) begin
            miscompares++;
            $display("FAIL rst_async: rv=%b data=%h busy=%b addr=%h expected all 0",
                     rd_valid, rd_data, busy, mem_addr);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || tdone_cnt != t0) begin
            miscompares++;
            $display("FAIL rst_after: busy=%b rv=%b pulses=%0d expected 0/0/0",
                     busy, rd_valid, tdone_cnt - t0);
        end
    endtask

`ifdef SLAVE_ADDR_CHECK_EN
    task automatic test_addr_check();
        send_cmd(2'b10, 12'h100, 12'd1);
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        tick();
        wr_valid = 1'b0;
        vectors++;
        if (mem_we !== 1'b0 || addr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL chk_wr: we=%b err=%b expected 0/1", mem_we, addr_err);
        end
        tick();
        tick();
        mem[12'h100] = 8'h5A;
        send_cmd(2'b11, 12'h100, 12'd1);
        tick();
        tick();
        vectors++;
        if ({rd_valid, rd_data, addr_err} !== {1'b1, 8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL chk_rd: rv=%b data=%h err=%b expected 1/00/1",
                     rd_valid, rd_data, addr_err);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++)
            mem[i] = 8'h00;
        test_reset();
        test_single_write();
        test_write_wrap();
        test_read_burst();
        test_burst_zero();
        test_illegal_instr();
        test_back_to_back();
`ifdef SLAVE_ADDR_CHECK_EN
        test_addr_check();
`else
        vectors++;
        if (addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_tied: err=%b expected 0", addr_err);
        end
`endif
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
